pwm_deadtime: RTL
=================

// Module: pwm_deadtime
// PURPOSE
//  Downstream stage of the APB4 PWM core. Takes the raw per-channel PWM levels (pwm_o of the PWM core)
//  and produces complementary high-side/low-side gate signals. Inserts a programmable dead time in which
//  both sides are off, and suppresses input pulses shorter than the dead time.
//  It sits between the PWM core and the pad/pinmux. Dead time, enable and polarity come from the SoC
//  register layer.
// PARAMETERS
//  CHN_NUM   4  number of independent channels (matches PWM core pwm_o width)
//  DT_WIDTH  8  width of dead-time count, in clk_i cycles
// PORTS
//  clk_i       in   1         core clock (same as PWM core pclk)
//  rst_i       in   1         asynchronous, active-high reset
//  en_i        in   1         global enable; 0 forces all channels to OFF
//  dt_i        in   DT_WIDTH  dead time in clk_i cycles; 0 = no dead time
//  pol_i       in   CHN_NUM   per-channel output inversion (1 = active-low gate outputs)
//  pwm_i       in   CHN_NUM   raw PWM levels from the PWM core
//  pwm_h_o     out  CHN_NUM   high-side gate = (state==HI) ^ pol_i[n]
//  pwm_l_o     out  CHN_NUM   low-side gate  = (state==LO) ^ pol_i[n]
//  busy_o      out  CHN_NUM   channel currently in DT state
//  brk_i       in   1         [PWM_DT_BRK_EN only] break request, synchronous to clk_i
//  brk_clr_i   in   1         [PWM_DT_BRK_EN only] single-cycle pulse, clears the break flag
//  brk_flag_o  out  1         [PWM_DT_BRK_EN only] sticky break-active flag
// BEHAVIOUR
//  - Each channel has its own FSM with states OFF/HI/LO/DT and a DT_WIDTH down-counter. Both are registered.
//  - Reset: state=OFF, cnt=0, busy_o=0, brk_flag_o=0. Gate outputs = pol_i (both sides inactive).
//  - Gate outputs are a combinational decode of the registered state. Latency from a pwm_i change to an
//    output change is 1 clk_i cycle.
//  - OFF: if en_i=1, go to HI when pwm_i=1, else go to LO. No dead time is needed because both sides are off.
//  - HI: if pwm_i=0 and dt_i=0, go to LO. If pwm_i=0 and dt_i!=0, go to DT and load cnt=dt_i.
//  - LO: the mirror of HI. Trigger is pwm_i=1, target is HI.
//  - DT: both sides off and busy_o=1. Each cycle cnt decrements. When cnt==1, leave to HI if pwm_i=1,
//    else to LO.
//    => both sides are off for exactly dt_i cycles.
//    The target is pwm_i sampled at exit, so a pulse shorter than dt_i is swallowed.
//    Exit can return to the pre-DT side.
//  - en_i=0 forces OFF next cycle from any state and clears cnt. This overrides every other transition.
//  - dt_i is sampled only when DT is entered. Changing it mid-DT does not affect the running count.
//  - pol_i acts combinationally, so changing it mid-run is glitch-prone. Software changes it only while en_i=0.
//  - Invariant, asserted in the bench: for every n, never (state==HI && state==LO). Also no direct
//    HI<->LO transition while dt_i!=0.
// CONFIGURATION
//  - PWM_DT_BRK_EN defined:
//    - brk_i=1 sets brk_flag_o next cycle. While brk_flag_o=1, all channels are held OFF (same priority as
//      en_i=0).
//    - brk_clr_i clears the flag only if brk_i=0 in the same cycle. If both are 1, the flag stays set.
//    - Channels resume through OFF the cycle after the flag clears.
//  - PWM_DT_BRK_EN undefined: brk_i, brk_clr_i and brk_flag_o do not exist, and there is no break logic.
// TESTING
//  1. Reset: rst_i=1 with pol_i=4'b0101 -> pwm_h_o=pwm_l_o=4'b0101 and busy_o=0. Release reset with
//     en_i=0 -> outputs unchanged.
//  2. dt_i=3, en_i=1, ch0 in HI, pwm_i[0] 1->0 at edge t -> h low from t+1, both off t+1..t+3,
//     l high at t+4, busy_o[0]=1 for 3 cycles.
//  3. dt_i=0, pwm_i[0] toggles every cycle -> h/l complementary, each output follows pwm_i with 1-cycle
//     delay, busy_o=0.
//  4. dt_i=4, ch1 in HI, pwm_i[1] low for 2 cycles only -> ch1 returns to HI after 4 off cycles,
//     l never asserts.
//  5. Mid-DT (cnt=2), set en_i=0 -> OFF next cycle. Re-enable with pwm_i=1 -> HI the following cycle.
//     Also: dt_i changed 3->8 mid-DT -> the current window is still 3 cycles.
//  6. PWM_DT_BRK_EN: brk_i pulse while running -> all OFF and brk_flag_o=1. brk_clr_i with brk_i=1 ->
//     flag stays 1. brk_clr_i with brk_i=0 -> flag 0, channels resume next cycle.

Source files
------------

// File: rtl/pwm_deadtime.sv
// Complementary high/low-side gate generator with programmable dead time and short-pulse suppression.
// Optional break input with sticky flag is built when PWM_DT_BRK_EN is defined.
module pwm_deadtime #(
    parameter int CHN_NUM  = 4,
    parameter int DT_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [DT_WIDTH-1:0] dt_i,
    input  logic [CHN_NUM-1:0]  pol_i,
    input  logic [CHN_NUM-1:0]  pwm_i,
`ifdef PWM_DT_BRK_EN
    input  logic                brk_i,
    input  logic                brk_clr_i,
    output logic                brk_flag_o,
`endif
    output logic [CHN_NUM-1:0]  pwm_h_o,
    output logic [CHN_NUM-1:0]  pwm_l_o,
    output logic [CHN_NUM-1:0]  busy_o
);

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_HI  = 2'd1,
        ST_LO  = 2'd2,
        ST_DT  = 2'd3
    } state_t;

    state_t              state_q [CHN_NUM];
    state_t              state_d [CHN_NUM];
    logic [DT_WIDTH-1:0] cnt_q   [CHN_NUM];
    logic [DT_WIDTH-1:0] cnt_d   [CHN_NUM];
    logic                hold;

`ifdef PWM_DT_BRK_EN
    logic brk_flag_q;

    // A simultaneous break request wins over a clear so a persisting fault cannot be acknowledged away.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            brk_flag_q <= 1'b0;
        end else if (brk_i) begin
            brk_flag_q <= 1'b1;
        end else if (brk_clr_i) begin
            brk_flag_q <= 1'b0;
        end
    end

    assign brk_flag_o = brk_flag_q;
    assign hold       = !en_i || brk_flag_q;
`else
    assign hold = !en_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < CHN_NUM; n++) begin
                state_q[n] <= ST_OFF;
                cnt_q[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < CHN_NUM; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
        end
    end

    // Leaving DT picks its side from pwm_i at exit, which is what swallows pulses shorter than the dead time.
    always_comb begin
        for (int n = 0; n < CHN_NUM; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            if (hold) begin
                state_d[n] = ST_OFF;
                cnt_d[n]   = '0;
            end else begin
                case (state_q[n])
                    ST_OFF: begin
                        state_d[n] = pwm_i[n] ? ST_HI : ST_LO;
                    end
                    ST_HI: begin
                        if (!pwm_i[n]) begin
                            if (dt_i == '0) begin
                                state_d[n] = ST_LO;
                            end else begin
                                state_d[n] = ST_DT;
                                cnt_d[n]   = dt_i;
                            end
                        end
                    end
                    ST_LO: begin
                        if (pwm_i[n]) begin
                            if (dt_i == '0) begin
                                state_d[n] = ST_HI;
                            end else begin
                                state_d[n] = ST_DT;
                                cnt_d[n]   = dt_i;
                            end
                        end
                    end
                    ST_DT: begin
                        if (cnt_q[n] == DT_WIDTH'(1)) begin
                            state_d[n] = pwm_i[n] ? ST_HI : ST_LO;
                            cnt_d[n]   = '0;
                        end else begin
                            cnt_d[n] = cnt_q[n] - DT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_d[n] = ST_OFF;
                        cnt_d[n]   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        pwm_h_o = pol_i;
        pwm_l_o = pol_i;
        busy_o  = '0;
        for (int n = 0; n < CHN_NUM; n++) begin
            pwm_h_o[n] = (state_q[n] == ST_HI) ^ pol_i[n];
            pwm_l_o[n] = (state_q[n] == ST_LO) ^ pol_i[n];
            busy_o[n]  = (state_q[n] == ST_DT);
        end
    end

endmodule
